// File: rtl/text_pkg.sv
// Shared definitions for the text blocks: HID keycodes, ASCII codes,
// the edit/commit state encoding and the keycode-to-character map.
package text_pkg;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_Z     = 8'h1D;
    localparam logic [7:0] KC_1     = 8'h1E;
    localparam logic [7:0] KC_9     = 8'h26;
    localparam logic [7:0] KC_0     = 8'h27;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_BKSP  = 8'h2A;
    localparam logic [7:0] KC_SPACE = 8'h2C;

    localparam logic [7:0] CH_BLANK  = 8'd0;
    localparam logic [7:0] CH_SPACE  = 8'd32;
    localparam logic [7:0] CH_ZERO   = 8'd48;
    localparam logic [7:0] CH_ONE    = 8'd49;
    localparam logic [7:0] CH_A      = 8'd65;
    localparam logic [7:0] CH_CURSOR = 8'd95;

    typedef enum logic {
        ST_EDIT   = 1'b0,
        ST_COMMIT = 1'b1
    } line_state_e;

    // Uppercase-only mapping; anything not printable returns CH_BLANK.
    function automatic logic [7:0] hid_to_ascii(input logic [7:0] kc);
        logic [7:0] ch;
        ch = CH_BLANK;
        if (kc >= KC_A && kc <= KC_Z) begin
            ch = kc - KC_A + CH_A;
        end else if (kc >= KC_1 && kc <= KC_9) begin
            ch = kc - KC_1 + CH_ONE;
        end else if (kc == KC_0) begin
            ch = CH_ZERO;
        end else if (kc == KC_SPACE) begin
            ch = CH_SPACE;
        end
        return ch;
    endfunction

endpackage

// File: rtl/input_line_editor_blink_timer.sv
// Cursor blink timer: free-running half-period counter whose phase flips on
// every wrap; a synchronous restart returns both to zero.
module blink_timer #(
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic restart,
    output logic blink_phase_next
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        phase_d = phase_q ^ wrap;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    // The editor registers its display from next-state values, so it needs the upcoming phase.
    assign blink_phase_next = phase_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/input_line_editor.sv
// Player-input line editor: HID keycodes in, zero-terminated display buffer
// with blinking cursor out, and a valid/ready handoff of the finished line.
module input_line_editor
    import text_pkg::*;
#(
    parameter int LEN          = 31,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       input_en,
    output int         player_input [0:LEN-1],
    output int         cmd_chars    [0:LEN-1],
    output logic [5:0] cmd_len,
    output logic       cmd_valid,
    input  logic       cmd_ready
);

    localparam logic [5:0] LEN_C = 6'(LEN);

    line_state_e state_q, state_d;
    logic [7:0]  key_q, key_d;
    logic [5:0]  cursor_q, cursor_d;
    logic [7:0]  line_q      [0:LEN-1];
    logic [7:0]  line_d      [0:LEN-1];
    logic [7:0]  disp_q      [0:LEN-1];
    logic [7:0]  disp_d      [0:LEN-1];
    logic [7:0]  cmd_chars_q [0:LEN-1];
    logic [7:0]  cmd_chars_d [0:LEN-1];
    logic [5:0]  cmd_len_q, cmd_len_d;
    logic        cmd_valid_q, cmd_valid_d;

    logic        key_event;
    logic [7:0]  key_char;
    logic        restart;
    logic        blink_phase_next;
    logic        show_cursor;

    blink_timer #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .vga_clk         (vga_clk),
        .reset_n         (reset_n),
        .restart         (restart),
        .blink_phase_next(blink_phase_next)
    );

    always_comb begin
        key_d       = keycode;
        key_event   = (keycode != KC_NONE) && (keycode != key_q);
        key_char    = hid_to_ascii(keycode);
        state_d     = state_q;
        cursor_d    = cursor_q;
        line_d      = line_q;
        cmd_chars_d = cmd_chars_q;
        cmd_len_d   = cmd_len_q;
        cmd_valid_d = cmd_valid_q;
        restart     = 1'b0;

        case (state_q)
            ST_EDIT: begin
                if (key_event && input_en) begin
                    if (keycode == KC_BKSP) begin
                        if (cursor_q != 6'd0) begin
                            cursor_d = cursor_q - 6'd1;
                            for (int i = 0; i < LEN; i++) begin
                                if (i == int'(cursor_d)) line_d[i] = CH_BLANK;
                            end
                            restart = 1'b1;
                        end
                    end else if (keycode == KC_ENTER) begin
                        if (cursor_q != 6'd0) begin
                            cmd_chars_d = line_q;
                            cmd_len_d   = cursor_q;
                            cmd_valid_d = 1'b1;
                            state_d     = ST_COMMIT;
                            restart     = 1'b1;
                        end
                    end else if (key_char != CH_BLANK && cursor_q < LEN_C) begin
                        for (int i = 0; i < LEN; i++) begin
                            if (i == int'(cursor_q)) line_d[i] = key_char;
                        end
                        cursor_d = cursor_q + 6'd1;
                        restart  = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                // Keystrokes are ignored until the consumer takes the line.
                if (cmd_ready) begin
                    state_d     = ST_EDIT;
                    cmd_valid_d = 1'b0;
                    cursor_d    = 6'd0;
                    for (int i = 0; i < LEN; i++) line_d[i] = CH_BLANK;
                    restart     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Blink phase 0 is the visible half, so a restart leaves the cursor solid after each edit.
    always_comb begin
        show_cursor = !blink_phase_next && input_en && (state_d == ST_EDIT)
                      && (cursor_d < LEN_C);
        for (int i = 0; i < LEN; i++) begin
            disp_d[i] = (show_cursor && i == int'(cursor_d)) ? CH_CURSOR : line_d[i];
        end
    end

    // NOTE: the character arrays are plain flops feeding the renderer, so they are reset like any other state.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EDIT;
            key_q       <= KC_NONE;
            cursor_q    <= 6'd0;
            cmd_len_q   <= 6'd0;
            cmd_valid_q <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                line_q[i]      <= CH_BLANK;
                disp_q[i]      <= CH_BLANK;
                cmd_chars_q[i] <= CH_BLANK;
            end
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cursor_q    <= cursor_d;
            cmd_len_q   <= cmd_len_d;
            cmd_valid_q <= cmd_valid_d;
            line_q      <= line_d;
            disp_q      <= disp_d;
            cmd_chars_q <= cmd_chars_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LEN; i++) begin
            player_input[i] = int'(disp_q[i]);
            cmd_chars[i]    = int'(cmd_chars_q[i]);
        end
    end

    assign cmd_len   = cmd_len_q;
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_input_line_editor.sv
// Self-checking bench for input_line_editor: directed steps plus random
// keystrokes, compared every cycle against a queue-based line model.
module tb_input_line_editor;

    localparam int LEN   = 31;
    localparam int BLINK = 4;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [7:0] keycode;
    logic       input_en;
    logic       cmd_ready;
    int         player_input [0:LEN-1];
    int         cmd_chars    [0:LEN-1];
    logic [5:0] cmd_len;
    logic       cmd_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_line[$];
    int         m_cmd [0:LEN-1];
    int         m_cmd_len;
    bit         m_committed;
    int         m_age;
    logic [7:0] m_prev;

    input_line_editor #(
        .LEN         (LEN),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .keycode     (keycode),
        .input_en    (input_en),
        .player_input(player_input),
        .cmd_chars   (cmd_chars),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int kc_to_char(input logic [7:0] kc);
        int k;
        k = int'(kc);
        if (k >= 4 && k <= 29)  return 65 + (k - 4);
        if (k >= 30 && k <= 38) return 49 + (k - 30);
        if (k == 39)            return 48;
        if (k == 44)            return 32;
        return 0;
    endfunction

    task automatic model_reset();
        m_line.delete();
        for (int i = 0; i < LEN; i++) m_cmd[i] = 0;
        m_cmd_len   = 0;
        m_committed = 0;
        m_age       = 0;
        m_prev      = 8'h00;
    endtask

    // One clock edge of the line-editing rules, using the inputs presented before it.
    task automatic model_edge();
        bit ev;
        bit rs;
        ev     = (keycode != 8'h00) && (keycode != m_prev);
        rs     = 0;
        m_prev = keycode;
        if (!m_committed) begin
            if (ev && input_en) begin
                if (keycode == 8'h2A) begin
                    if (m_line.size() > 0) begin
                        void'(m_line.pop_back());
                        rs = 1;
                    end
                end else if (keycode == 8'h28) begin
                    if (m_line.size() > 0) begin
                        for (int i = 0; i < LEN; i++) m_cmd[i] = (i < m_line.size()) ? m_line[i] : 0;
                        m_cmd_len   = m_line.size();
                        m_committed = 1;
                        rs = 1;
                    end
                end else if (kc_to_char(keycode) != 0 && m_line.size() < LEN) begin
                    m_line.push_back(kc_to_char(keycode));
                    rs = 1;
                end
            end
        end else if (cmd_ready) begin
            m_committed = 0;
            m_line.delete();
            rs = 1;
        end
        m_age = rs ? 0 : m_age + 1;
    endtask

    function automatic int exp_disp(input int i);
        int v;
        v = (i < m_line.size()) ? m_line[i] : 0;
        if (!m_committed && input_en && m_line.size() < LEN
            && ((m_age / BLINK) % 2 == 0) && i == m_line.size()) v = 95;
        return v;
    endfunction

    task automatic check_all();
        for (int i = 0; i < LEN; i++) begin
            check($sformatf("player_input[%0d]", i), player_input[i], exp_disp(i));
            check($sformatf("cmd_chars[%0d]", i), cmd_chars[i], m_cmd[i]);
        end
        check("cmd_len", 32'(cmd_len), m_cmd_len);
        check("cmd_valid", 32'(cmd_valid), 32'(m_committed));
    endtask

    task automatic check_reset();
        for (int i = 0; i < LEN; i++) begin
            check($sformatf("rst player_input[%0d]", i), player_input[i], 0);
            check($sformatf("rst cmd_chars[%0d]", i), cmd_chars[i], 0);
        end
        check("rst cmd_len", 32'(cmd_len), 0);
        check("rst cmd_valid", 32'(cmd_valid), 0);
    endtask

    task automatic step(input logic [7:0] kc, input logic en, input logic rdy);
        keycode   = kc;
        input_en  = en;
        cmd_ready = rdy;
        @(posedge vga_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input logic [7:0] kc, input logic en, input logic rdy, input int n);
        repeat (n) step(kc, en, rdy);
    endtask

    task automatic press(input logic [7:0] kc);
        step(kc, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b1;
        keycode   = 8'h00;
        input_en  = 1'b1;
        cmd_ready = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #16;
        check_reset();
        reset_n = 1'b1;

        // "HI" with each key held and released for three cycles
        hold(8'h0B, 1'b1, 1'b0, 3);
        hold(8'h00, 1'b1, 1'b0, 3);
        hold(8'h0C, 1'b1, 1'b0, 3);
        hold(8'h00, 1'b1, 1'b0, 3);
        check("H written", player_input[0], 72);
        check("I written", player_input[1], 73);

        // Long hold gives one character; a direct change fires the new key
        hold(8'h04, 1'b1, 1'b0, 100);
        hold(8'h05, 1'b1, 1'b0, 2);
        step(8'h00, 1'b1, 1'b0);
        check("A once", player_input[2], 65);
        check("B appended", player_input[3], 66);

        // Overfill the line, then one more key, then backspace past empty
        for (int k = 0; k < 40; k++) press(8'(4 + $urandom_range(0, 25)));
        press(8'h04);
        check("full line keeps last", player_input[LEN-1], m_line[LEN-1]);
        for (int k = 0; k < 32; k++) press(8'h2A);
        check("cleared pos1", player_input[1], 0);
        check("cleared pos30", player_input[LEN-1], 0);

        // "GO" + Enter held off by the consumer, with ignored keystrokes
        press(8'h0A);
        press(8'h12);
        press(8'h28);
        for (int k = 0; k < 10; k++) begin
            step((k % 2 == 0) ? 8'(4 + k) : 8'h2A, 1'b1, 1'b0);
            check("cmd_valid held", 32'(cmd_valid), 1);
        end
        check("cmd_chars[0]", cmd_chars[0], 71);
        check("cmd_chars[1]", cmd_chars[1], 79);
        check("cmd_len GO", 32'(cmd_len), 2);
        step(8'h00, 1'b1, 1'b1);
        check("accept drops valid", 32'(cmd_valid), 0);
        check("accept cursor glyph", player_input[0], 95);
        check("accept keeps cmd_len", 32'(cmd_len), 2);
        step(8'h00, 1'b1, 1'b1);

        // Enter on an empty line, then idle blinking
        press(8'h28);
        check("empty enter", 32'(cmd_valid), 0);
        hold(8'h00, 1'b1, 1'b0, 16);

        // Random keystrokes, enables and consumer readiness
        for (int k = 0; k < 1200; k++) begin
            logic [7:0] kc;
            int         r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: kc = 8'h00;
                3, 4, 5: kc = 8'($urandom_range(4, 39));
                6:       kc = 8'h2C;
                7:       kc = 8'h2A;
                8:       kc = 8'h28;
                default: kc = 8'($urandom_range(0, 255));
            endcase
            hold(kc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(1, 3)));
        end

        // Asynchronous reset in the middle of a pending command
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        press(8'h1B);
        press(8'h28);
        check("commit before reset", 32'(cmd_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        #3 reset_n = 1'b1;
        hold(8'h00, 1'b1, 1'b0, 6);
        press(8'h0B);
        check("after reset H", player_input[0], 72);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
